// File: rtl/bridge_pkg.sv
// bridge_pkg: shared definitions for the CPU-to-peripheral bridge.
//   - FSM state encoding (IDLE/ACCESS/RESP, binary)
//   - device window, device count, slot width
//   - address field positions for device index and word offset
//   - addr_ok(): window and alignment check for one CPU address
`timescale 1ns/1ps
package bridge_pkg;

    localparam int NDEV    = 8;
    localparam int SLOT_W  = 32;
    localparam int IDX_HI  = 6;
    localparam int IDX_LO  = 4;
    localparam int WORD_HI = 3;
    localparam int WORD_LO = 2;

    localparam logic [24:0] WINDOW = 25'h0FE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // True when the address is inside the device window and word aligned.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[31:7] == WINDOW) && (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/bridge_dev_dec.sv
// bridge_dev_dec: combinational device decode.
//   idx        in   3    device index
//   dev_rdata  in   256  flat read data, slot i at [32i+31:32i]
//   sel        out  8    one-hot select for idx
//   rdata      out  32   read data of slot idx
`timescale 1ns/1ps
module bridge_dev_dec
    import bridge_pkg::*;
(
    input  logic [2:0]             idx,
    input  logic [NDEV*SLOT_W-1:0] dev_rdata,
    output logic [NDEV-1:0]        sel,
    output logic [SLOT_W-1:0]      rdata
);

    always_comb begin
        sel   = NDEV'(1) << idx;
        rdata = dev_rdata[{idx, 5'b00000} +: SLOT_W];
    end

endmodule

// File: rtl/bridge_demux.sv
// bridge_demux: decodes one CPU load/store onto 8 memory-mapped devices,
// waits for the selected device to acknowledge, and returns a one-cycle
// cpu_ready with registered read data and an error flag.
//   clk, rst_n             clock, async active-low reset
//   cpu_req/we/addr/wdata  CPU request (sampled only in IDLE)
//   cpu_ready/err/rdata    completion pulse, error, load data (RESP only)
//   dev_sel/we/addr/wdata  registered device-side request (ACCESS only)
//   dev_rdata, dev_ready   flat device read data, per-device acknowledge
// Handshake: a request is taken when cpu_req=1 in IDLE; exactly one
// cpu_ready pulse follows; a device transfer completes on the ACCESS cycle
// in which the selected device's dev_ready bit is 1.
`timescale 1ns/1ps
module bridge_demux
    import bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic         cpu_ready,
    output logic         cpu_err,
    output logic [31:0]  cpu_rdata,
    output logic [7:0]   dev_sel,
    output logic         dev_we,
    output logic [1:0]   dev_addr,
    output logic [31:0]  dev_wdata,
    input  logic [255:0] dev_rdata,
    input  logic [7:0]   dev_ready
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [2:0]  lat_idx;
    logic        lat_we;

    logic [2:0]  dec_idx;
    logic [7:0]  dec_sel;
    logic [31:0] dec_rdata;
    logic        req_ok;
    logic        sel_ready;
    logic        timeout_hit;

    // In IDLE the decoder looks at the incoming address; afterwards it
    // follows the latched index so the request is stable through ACCESS.
    assign dec_idx = (state == ST_IDLE) ? cpu_addr[IDX_HI:IDX_LO] : lat_idx;

    bridge_dev_dec u_dec (
        .idx       (dec_idx),
        .dev_rdata (dev_rdata),
        .sel       (dec_sel),
        .rdata     (dec_rdata)
    );

    assign req_ok      = addr_ok(cpu_addr);
    assign sel_ready   = dev_ready[lat_idx];
    // cnt counts completed ACCESS cycles; cnt+1 is the current one.
    assign timeout_hit = ((cnt + 8'd1) == TIMEOUT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cpu_req) state_nx = req_ok ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                if (sel_ready || timeout_hit) state_nx = ST_RESP;
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output and datapath registers. cpu_* default to 0 every cycle so they
    // are only non-zero during the single RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_idx   <= '0;
            lat_we    <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            dev_sel   <= '0;
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (cpu_req) begin
                        lat_idx <= cpu_addr[IDX_HI:IDX_LO];
                        lat_we  <= cpu_we;
                        if (req_ok) begin
                            dev_sel   <= dec_sel;
                            dev_we    <= cpu_we;
                            dev_addr  <= cpu_addr[WORD_HI:WORD_LO];
                            dev_wdata <= cpu_wdata;
                        end else begin
                            // Decode error: answer next cycle, no device touched.
                            cpu_ready <= 1'b1;
                            cpu_err   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 8'd1;
                    // Ready has priority over a coincident timeout.
                    if (sel_ready || timeout_hit) begin
                        cpu_ready <= 1'b1;
                        cpu_err   <= !sel_ready;
                        cpu_rdata <= (sel_ready && !lat_we) ? dec_rdata : '0;
                        dev_sel   <= '0;
                        dev_we    <= 1'b0;
                        dev_addr  <= '0;
                        dev_wdata <= '0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/bridge_demux.md
Name: bridge_demux

Overview:
- CPU-side system bridge: the write/request-distribution end of the peripheral read-back path.
- Decodes one CPU load/store into a one-hot device select among 8 memory-mapped devices (timers, I/O).
- Holds the request until the selected device acknowledges, then returns registered read data and a one-cycle ready to the CPU pipeline (MEM stage).
- Flags unmapped, misaligned or timed-out accesses so CP0 can raise AdEL/AdES.

Parameters:
- NDEV, 8, number of device slots; fixed at 8 (3-bit index).
- WINDOW, 25'h0FE, required value of cpu_addr[31:7]; device window is 0x0000_7F00–0x0000_7F7F.
- TIMEOUT, 15, maximum ACCESS cycles without dev_ready before error; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ready; 1 = address or timeout error.
- cpu_rdata  out  32  load data; valid with cpu_ready; 0 on store or error.
- dev_sel  out  8  one-hot device select; held through ACCESS.
- dev_we  out  1  write strobe to the selected device.
- dev_addr  out  2  word offset within the device (cpu_addr[3:2]).
- dev_wdata  out  32  store data to the device.
- dev_rdata  in  256  device read data, flat; slot i occupies bits [32i+31:32i].
- dev_ready  in  8  per-device acknowledge.

Behaviour:
- Reset (rst_n low, async): state IDLE; every output 0; timeout counter 0; latched request cleared.
- States are IDLE, ACCESS and RESP; encoding is binary 2'b00, 2'b01, 2'b10.
- IDLE with cpu_req=1: latch cpu_we, cpu_addr[6:2] and cpu_wdata.
  - If cpu_addr[31:7]!=WINDOW or cpu_addr[1:0]!=0: set err, go to RESP. No device is selected.
  - Otherwise go to ACCESS.
- IDLE with cpu_req=0: all outputs 0.
- ACCESS:
  - Registered outputs: dev_sel=1<<idx with idx=addr[6:4]; dev_we=latched we; dev_addr; dev_wdata.
  - Counter increments each ACCESS cycle.
  - If dev_ready[idx]=1: for a load, capture dev_rdata slot idx into cpu_rdata; clear err; go to RESP.
  - Else, if counter==TIMEOUT: set err, force cpu_rdata=0, go to RESP.
  - If ready and timeout coincide, ready wins.
  - dev_ready bits of non-selected slots are ignored.
- RESP (one cycle):
  - cpu_ready=1; cpu_err=err.
  - dev_sel=0 and dev_we=0.
  - Next state IDLE; counter cleared.
- cpu_rdata and cpu_err hold their values only in the RESP cycle and are 0 otherwise.
- cpu_req is ignored in ACCESS and RESP. The CPU stalls while cpu_req is high and cpu_ready is low. The next request is accepted in the IDLE cycle after RESP.
- Latency:
  - Best-case load/store: request cycle → ACCESS → RESP, i.e. cpu_ready 2 cycles after request acceptance.
  - Error from decode: cpu_ready 1 cycle after request.
  - Timeout: cpu_ready TIMEOUT+1 cycles after acceptance.
- dev_we is a level held for the whole ACCESS. A device commits the write on the cycle it asserts dev_ready; the bridge never issues a second write for one request.
- Reset asserted mid-ACCESS: dev_sel and dev_we drop immediately (async) and the transaction is abandoned. No cpu_ready is produced.

Decomposition:
- Shared package bridge_pkg: state encodings, WINDOW, NDEV, index field positions (6:4), word field (3:2), slot width 32.
- One sub-module, bridge_dev_dec: combinational 3-to-8 one-hot decoder plus 8:1 32-bit read-data select from the flat bus.
- FSM, counter and output registers stay in bridge_demux.

Test Plan:
- Store 0x7F14 ← 0xDEADBEEF, dev_ready[1] asserted in the first ACCESS cycle.
  - ACCESS: dev_sel=8'b0000_0010, dev_we=1, dev_addr=1, dev_wdata=0xDEADBEEF.
  - Next cycle: cpu_ready=1, cpu_err=0.
- Load 0x7F28, dev_rdata slot 2=0x12345678, dev_ready[2] after 3 cycles.
  - dev_sel=8'b0000_0100 held 3 cycles.
  - Then cpu_ready=1, cpu_rdata=0x12345678.
- Load 0x7F30, slot 3 never ready → after 15 ACCESS cycles: cpu_ready=1, cpu_err=1, cpu_rdata=0.
- Address 0x8000 and address 0x7F02 → next cycle cpu_ready=1, cpu_err=1; dev_sel stays 0 throughout.
- Load 0x7F00 with dev_ready=8'b1111_1110 (others ready, slot 0 not) → bridge keeps waiting. Then dev_ready[0]=1 coincident with the 15th ACCESS cycle → cpu_err=0.
- rst_n pulled low mid-ACCESS → dev_sel=0 asynchronously, no cpu_ready. After release, a new store to 0x7F10 completes normally.
